// File: rtl/fpga_memory_pkg.sv
// rtl/fpga_memory_pkg.sv - shared constants and types for the fpga_memory hub
package fpga_memory_pkg;

    // BRAM_SELECT region decode
    localparam logic [1:0] BRAM_SEL_CTL = 2'b00;
    localparam logic [1:0] BRAM_SEL_MOD = 2'b01;
    localparam logic [1:0] BRAM_SEL_PWE = 2'b10;
    localparam logic [1:0] BRAM_SEL_STM = 2'b11;

    // Controller sub-regions, decoded on ADDR[14:13]
    localparam logic [1:0] CTL_SUB_REG   = 2'b00;
    localparam logic [1:0] CTL_SUB_CLOCK = 2'b01;
    localparam logic [1:0] CTL_SUB_CNT   = 2'b10;
    localparam logic [1:0] CTL_SUB_NONE  = 2'b11;

    // Control register holding {page[3:0], segment} for host STM writes
    localparam logic [7:0] ADDR_STM_SEG = 8'h10;

    typedef enum logic {
        STM_MODE_GAIN  = 1'b0,
        STM_MODE_FOCUS = 1'b1
    } stm_mode_t;

    // Source of the host readback word, chosen one cycle after the read
    typedef enum logic [2:0] {
        RB_NONE = 3'd0,
        RB_CTL  = 3'd1,
        RB_MOD  = 3'd2,
        RB_PWE  = 3'd3,
        RB_STM  = 3'd4
    } rb_src_t;

endpackage

// File: rtl/fpga_memory_stm_memory.sv
// rtl/fpga_memory_stm_memory.sv - dual-segment paged STM storage with gain/focus reads; optional FPGA_MEMORY_READBACK_EN
module fpga_memory_stm_memory #(
    parameter int DEPTH      = 249,
    parameter int STM_ADDR_W = 15
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    i_wr_en,
    input  logic [STM_ADDR_W+4:0]   i_wr_addr,
    input  logic [15:0]             i_wr_data,
    input  logic [STM_ADDR_W+1:0]   i_rd_idx,
    input  logic [7:0]              i_rd_tr,
    input  logic                    i_rd_segment,
    input  logic                    i_rd_mode,
    output logic [63:0]             o_rd_data
`ifdef FPGA_MEMORY_READBACK_EN
    ,
    input  logic                    i_hrd_en,
    input  logic [STM_ADDR_W+4:0]   i_hrd_addr,
    output logic [15:0]             o_hrd_data
`endif
);
    import fpga_memory_pkg::*;

    // Four word banks so a focus point (4 consecutive words) reads in one access
    localparam int LINE_W = STM_ADDR_W + 3;
    localparam int ROW_W  = STM_ADDR_W - 4;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [15:0]       r_mem [0:3][0:(2**LINE_W)-1];
    logic [LINE_W-1:0] r_line;
    logic [1:0]        r_bank;
    stm_mode_t         r_mode;
    logic              r_oor;

    // Host write: bank is the low two word-address bits, line the rest
    always_ff @(posedge CLK) begin
        if (i_wr_en)
            r_mem[i_wr_addr[1:0]][i_wr_addr[STM_ADDR_W+4:2]] <= i_wr_data;
    end

    // Read stage 1: register line/bank; a gain row is 256 words so row r starts at r*256
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_line <= '0;
            r_bank <= '0;
            r_mode <= STM_MODE_GAIN;
            r_oor  <= 1'b0;
        end else begin
            r_mode <= stm_mode_t'(i_rd_mode);
            r_bank <= i_rd_tr[1:0];
            r_oor  <= (i_rd_mode == STM_MODE_GAIN) && ({1'b0, i_rd_tr} >= DEPTH_L);
            if (i_rd_mode == STM_MODE_FOCUS)
                r_line <= {i_rd_segment, i_rd_idx};
            else
                r_line <= {i_rd_segment, i_rd_idx[ROW_W-1:0], i_rd_tr[7:2]};
        end
    end

    // Read stage 2: format gain word or the four focus words; transducers past DEPTH read 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            o_rd_data <= '0;
        else if (r_mode == STM_MODE_FOCUS)
            o_rd_data <= {r_mem[3][r_line], r_mem[2][r_line], r_mem[1][r_line], r_mem[0][r_line]};
        else if (r_oor)
            o_rd_data <= '0;
        else
            o_rd_data <= {48'd0, r_mem[r_bank][r_line]};
    end

`ifdef FPGA_MEMORY_READBACK_EN
    // Host readback port, one registered stage behind the top's address stage
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            o_hrd_data <= '0;
        else if (i_hrd_en)
            o_hrd_data <= r_mem[i_hrd_addr[1:0]][i_hrd_addr[STM_ADDR_W+4:2]];
    end
`endif

endmodule

// File: rtl/fpga_memory.sv
// rtl/fpga_memory.sv - host BRAM bus to controller/clock/counter/mod/STM/PWE storage hub; optional FPGA_MEMORY_READBACK_EN
module fpga_memory #(
    parameter int DEPTH      = 249,
    parameter int STM_ADDR_W = 15
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MRCC_25P6M,
    // host BRAM bus
    input  logic                  i_mem_en,
    input  logic                  i_mem_we,
    input  logic [1:0]            i_mem_bram_select,
    input  logic [14:0]           i_mem_addr,
    input  logic [15:0]           i_mem_data_in,
    output logic [15:0]           o_mem_data_out,
    // clock-configuration window
    output logic                  o_clock_mrcc,
    output logic                  o_clock_we,
    output logic [12:0]           o_clock_addr,
    output logic [15:0]           o_clock_data,
    // counter-table window
    output logic                  o_cnt_we,
    output logic [12:0]           o_cnt_addr,
    output logic [15:0]           o_cnt_data,
    // modulation reads
    input  logic [14:0]           i_mod_idx,
    input  logic                  i_mod_segment,
    output logic [7:0]            o_mod_value,
    // STM reads
    input  logic [STM_ADDR_W+1:0] i_stm_idx,
    input  logic [7:0]            i_stm_tr,
    input  logic                  i_stm_segment,
    input  logic                  i_stm_mode,
    output logic [63:0]           o_stm_data,
    // PWE table reads
    input  logic [7:0]            i_pwe_idx,
    output logic [7:0]            o_pwe_value
);
    import fpga_memory_pkg::*;

    localparam int STM_WA = STM_ADDR_W + 5;

    logic [4:0]  r_stm_ctrl;
    logic [15:0] r_cr_mem  [0:255];
    logic [15:0] r_mod_mem [0:32767];
    logic [7:0]  r_pwe_mem [0:255];

    // Write decode; writes while in reset are dropped
    wire [1:0] w_sub      = i_mem_addr[14:13];
    wire       w_wr       = RST_N & i_mem_en & i_mem_we;
    wire       w_rd       = i_mem_en & ~i_mem_we;
    wire       w_sel_ctl  = (i_mem_bram_select == BRAM_SEL_CTL);
    wire       w_cr_wr    = w_wr & w_sel_ctl & (w_sub == CTL_SUB_REG) & (i_mem_addr[12:8] == 5'd0);
    wire       w_clk_wr   = w_wr & w_sel_ctl & (w_sub == CTL_SUB_CLOCK);
    wire       w_cnt_wr   = w_wr & w_sel_ctl & (w_sub == CTL_SUB_CNT);
    wire       w_mod_wr   = w_wr & (i_mem_bram_select == BRAM_SEL_MOD);
    wire       w_pwe_wr   = w_wr & (i_mem_bram_select == BRAM_SEL_PWE) & (i_mem_addr[14:8] == 7'd0);
    wire       w_stm_wr   = w_wr & (i_mem_bram_select == BRAM_SEL_STM);
    wire [STM_WA-1:0] w_stm_waddr = {r_stm_ctrl[0], r_stm_ctrl[4:1], i_mem_addr[STM_ADDR_W-1:0]};

    assign o_clock_mrcc = MRCC_25P6M;

    // STM segment/page register, the only control register with a reset value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_stm_ctrl <= '0;
        else if (w_cr_wr && (i_mem_addr[7:0] == ADDR_STM_SEG))
            r_stm_ctrl <= i_mem_data_in[4:0];
    end

    // Host writes into the plain RAM regions; contents are never reset
    always_ff @(posedge CLK) begin
        if (w_cr_wr)
            r_cr_mem[i_mem_addr[7:0]] <= i_mem_data_in;
        if (w_mod_wr)
            r_mod_mem[i_mem_addr] <= i_mem_data_in;
        if (w_pwe_wr)
            r_pwe_mem[i_mem_addr[7:0]] <= i_mem_data_in[7:0];
    end

    // Clock and counter windows: single-cycle strobe with address/data one cycle after the write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_clock_we   <= 1'b0;
            o_clock_addr <= '0;
            o_clock_data <= '0;
            o_cnt_we     <= 1'b0;
            o_cnt_addr   <= '0;
            o_cnt_data   <= '0;
        end else begin
            o_clock_we <= w_clk_wr;
            o_cnt_we   <= w_cnt_wr;
            if (w_clk_wr) begin
                o_clock_addr <= i_mem_addr[12:0];
                o_clock_data <= i_mem_data_in;
            end
            if (w_cnt_wr) begin
                o_cnt_addr <= i_mem_addr[12:0];
                o_cnt_data <= i_mem_data_in;
            end
        end
    end

    logic [14:0] r_mod_waddr;
    logic        r_mod_hi;
    logic [7:0]  r_pwe_idx;

    // Modulation/PWE consumer reads: address stage then read-first data stage
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mod_waddr <= '0;
            r_mod_hi    <= 1'b0;
            r_pwe_idx   <= '0;
            o_mod_value <= '0;
            o_pwe_value <= '0;
        end else begin
            r_mod_waddr <= {i_mod_segment, i_mod_idx[14:1]};
            r_mod_hi    <= i_mod_idx[0];
            r_pwe_idx   <= i_pwe_idx;
            o_mod_value <= r_mod_hi ? r_mod_mem[r_mod_waddr][15:8] : r_mod_mem[r_mod_waddr][7:0];
            o_pwe_value <= r_pwe_mem[r_pwe_idx];
        end
    end

    logic        r_rd_valid;
    logic [1:0]  r_rd_sel;
    logic [14:0] r_rd_addr;
    rb_src_t     r_rb_src;
    rb_src_t     w_rd_src;
    logic [15:0] r_rb_cr;
`ifdef FPGA_MEMORY_READBACK_EN
    logic [4:0]  r_rd_stm_ctrl;
    logic [15:0] r_rb_mod;
    logic [7:0]  r_rb_pwe;
    logic [15:0] w_rb_stm;
`endif

    // Which region answers the registered host read address
    always_comb begin
        w_rd_src = RB_NONE;
        case (r_rd_sel)
            BRAM_SEL_CTL:
                if ((r_rd_addr[14:13] == CTL_SUB_REG) && (r_rd_addr[12:8] == 5'd0))
                    w_rd_src = RB_CTL;
`ifdef FPGA_MEMORY_READBACK_EN
            BRAM_SEL_MOD: w_rd_src = RB_MOD;
            BRAM_SEL_PWE:
                if (r_rd_addr[14:8] == 7'd0)
                    w_rd_src = RB_PWE;
            BRAM_SEL_STM: w_rd_src = RB_STM;
`endif
            default: w_rd_src = RB_NONE;
        endcase
    end

    // Host read stage 1: capture the read request
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= '0;
            r_rd_addr  <= '0;
`ifdef FPGA_MEMORY_READBACK_EN
            r_rd_stm_ctrl <= '0;
`endif
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_sel  <= i_mem_bram_select;
                r_rd_addr <= i_mem_addr;
`ifdef FPGA_MEMORY_READBACK_EN
                r_rd_stm_ctrl <= r_stm_ctrl;
`endif
            end
        end
    end

    // Host read stage 2: fetch region data; DATA_OUT holds until the next read
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rb_src <= RB_NONE;
            r_rb_cr  <= '0;
`ifdef FPGA_MEMORY_READBACK_EN
            r_rb_mod <= '0;
            r_rb_pwe <= '0;
`endif
        end else if (r_rd_valid) begin
            r_rb_src <= w_rd_src;
            r_rb_cr  <= (r_rd_addr[7:0] == ADDR_STM_SEG) ? {11'd0, r_stm_ctrl}
                                                         : r_cr_mem[r_rd_addr[7:0]];
`ifdef FPGA_MEMORY_READBACK_EN
            r_rb_mod <= r_mod_mem[r_rd_addr];
            r_rb_pwe <= r_pwe_mem[r_rd_addr[7:0]];
`endif
        end
    end

    // Readback mux over the stage-2 registers
    always_comb begin
        o_mem_data_out = '0;
        case (r_rb_src)
            RB_CTL: o_mem_data_out = r_rb_cr;
`ifdef FPGA_MEMORY_READBACK_EN
            RB_MOD: o_mem_data_out = r_rb_mod;
            RB_PWE: o_mem_data_out = {8'd0, r_rb_pwe};
            RB_STM: o_mem_data_out = w_rb_stm;
`endif
            default: o_mem_data_out = '0;
        endcase
    end

    fpga_memory_stm_memory #(
        .DEPTH      (DEPTH),
        .STM_ADDR_W (STM_ADDR_W)
    ) u_stm_memory (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_wr_en      (w_stm_wr),
        .i_wr_addr    (w_stm_waddr),
        .i_wr_data    (i_mem_data_in),
        .i_rd_idx     (i_stm_idx),
        .i_rd_tr      (i_stm_tr),
        .i_rd_segment (i_stm_segment),
        .i_rd_mode    (i_stm_mode),
        .o_rd_data    (o_stm_data)
`ifdef FPGA_MEMORY_READBACK_EN
        ,
        .i_hrd_en     (r_rd_valid),
        .i_hrd_addr   ({r_rd_stm_ctrl[0], r_rd_stm_ctrl[4:1], r_rd_addr[STM_ADDR_W-1:0]}),
        .o_hrd_data   (w_rb_stm)
`endif
    );

endmodule

// File: tb/tb_fpga_memory.sv
// tb/tb_fpga_memory.sv - directed self-checking bench for fpga_memory; honours FPGA_MEMORY_READBACK_EN
module tb_fpga_memory;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        MRCC_25P6M = 1'b0;
    logic        i_mem_en = 1'b0;
    logic        i_mem_we = 1'b0;
    logic [1:0]  i_mem_bram_select = '0;
    logic [14:0] i_mem_addr = '0;
    logic [15:0] i_mem_data_in = '0;
    logic [15:0] o_mem_data_out;
    logic        o_clock_mrcc, o_clock_we, o_cnt_we;
    logic [12:0] o_clock_addr, o_cnt_addr;
    logic [15:0] o_clock_data, o_cnt_data;
    logic [14:0] i_mod_idx = '0;
    logic        i_mod_segment = 1'b0;
    logic [7:0]  o_mod_value;
    logic [16:0] i_stm_idx = '0;
    logic [7:0]  i_stm_tr = '0;
    logic        i_stm_segment = 1'b0;
    logic        i_stm_mode = 1'b0;
    logic [63:0] o_stm_data;
    logic [7:0]  i_pwe_idx = '0;
    logic [7:0]  o_pwe_value;

    fpga_memory #(.DEPTH(249), .STM_ADDR_W(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .MRCC_25P6M(MRCC_25P6M),
        .i_mem_en(i_mem_en), .i_mem_we(i_mem_we), .i_mem_bram_select(i_mem_bram_select),
        .i_mem_addr(i_mem_addr), .i_mem_data_in(i_mem_data_in), .o_mem_data_out(o_mem_data_out),
        .o_clock_mrcc(o_clock_mrcc), .o_clock_we(o_clock_we), .o_clock_addr(o_clock_addr),
        .o_clock_data(o_clock_data), .o_cnt_we(o_cnt_we), .o_cnt_addr(o_cnt_addr),
        .o_cnt_data(o_cnt_data), .i_mod_idx(i_mod_idx), .i_mod_segment(i_mod_segment),
        .o_mod_value(o_mod_value), .i_stm_idx(i_stm_idx), .i_stm_tr(i_stm_tr),
        .i_stm_segment(i_stm_segment), .i_stm_mode(i_stm_mode), .o_stm_data(o_stm_data),
        .i_pwe_idx(i_pwe_idx), .o_pwe_value(o_pwe_value)
    );

    always #5 CLK = ~CLK;
    always #19 MRCC_25P6M = ~MRCC_25P6M;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp0 [0:15][0:255];
    logic [15:0] exp1 [0:3][0:255];
    logic [15:0] rd;
    logic [7:0]  rb;
    logic [63:0] rs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All access tasks start and end on a falling edge
    task automatic host_write(input logic [1:0] sel, input logic [14:0] addr, input logic [15:0] data);
        i_mem_en = 1'b1; i_mem_we = 1'b1; i_mem_bram_select = sel;
        i_mem_addr = addr; i_mem_data_in = data;
        @(negedge CLK);
        i_mem_en = 1'b0; i_mem_we = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] sel, input logic [14:0] addr, output logic [15:0] data);
        i_mem_en = 1'b1; i_mem_we = 1'b0; i_mem_bram_select = sel; i_mem_addr = addr;
        @(negedge CLK);
        i_mem_en = 1'b0;
        @(negedge CLK);
        data = o_mem_data_out;
    endtask

    task automatic mod_read(input logic seg, input logic [14:0] idx, output logic [7:0] v);
        i_mod_segment = seg; i_mod_idx = idx;
        repeat (2) @(negedge CLK);
        v = o_mod_value;
    endtask

    task automatic pwe_read(input logic [7:0] idx, output logic [7:0] v);
        i_pwe_idx = idx;
        repeat (2) @(negedge CLK);
        v = o_pwe_value;
    endtask

    task automatic stm_read(input logic mode, input logic seg, input logic [16:0] idx,
                            input logic [7:0] tr, output logic [63:0] v);
        i_stm_mode = mode; i_stm_segment = seg; i_stm_idx = idx; i_stm_tr = tr;
        repeat (2) @(negedge CLK);
        v = o_stm_data;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_data_out", 64'(o_mem_data_out), 64'h0);
        check("rst_mod_value", 64'(o_mod_value), 64'h0);
        check("rst_pwe_value", 64'(o_pwe_value), 64'h0);
        check("rst_stm_data", o_stm_data, 64'h0);
        check("rst_clock_we", 64'(o_clock_we), 64'h0);
        check("mrcc_fwd", 64'(o_clock_mrcc), 64'(MRCC_25P6M));
        RST_N = 1'b1;
        @(negedge CLK);

        host_write(2'b00, 15'h0005, 16'h1234);
        host_read(2'b00, 15'h0005, rd);
        check("cr5_readback", 64'(rd), 64'h1234);
        host_read(2'b00, 15'h0010, rd);
        check("stm_ctrl_rst", 64'(rd), 64'h0);

        host_write(2'b00, 15'h2003, 16'h5555);
        check("clk_we_pulse", 64'(o_clock_we), 64'h1);
        check("clk_addr", 64'(o_clock_addr), 64'h3);
        check("clk_data", 64'(o_clock_data), 64'h5555);
        check("cnt_we_quiet", 64'(o_cnt_we), 64'h0);
        @(negedge CLK);
        check("clk_we_single", 64'(o_clock_we), 64'h0);

        host_write(2'b00, 15'h4007, 16'hA5A5);
        check("cnt_we_pulse", 64'(o_cnt_we), 64'h1);
        check("cnt_addr", 64'(o_cnt_addr), 64'h7);
        check("cnt_data", 64'(o_cnt_data), 64'hA5A5);

        host_write(2'b00, 15'h6005, 16'hDEAD);
        check("sub11_no_clk", 64'(o_clock_we), 64'h0);
        check("sub11_no_cnt", 64'(o_cnt_we), 64'h0);
        host_read(2'b00, 15'h0005, rd);
        check("sub11_cr5_kept", 64'(rd), 64'h1234);

        host_write(2'b01, 15'h4000, 16'hBEEF);
        mod_read(1'b1, 15'd0, rb);
        check("mod_s1_idx0", 64'(rb), 64'hEF);
        mod_read(1'b1, 15'd1, rb);
        check("mod_s1_idx1", 64'(rb), 64'hBE);
        host_write(2'b01, 15'h0005, 16'h1122);
        mod_read(1'b0, 15'd10, rb);
        check("mod_next_cycle", 64'(rb), 64'h22);
        host_read(2'b01, 15'h4000, rd);
`ifdef FPGA_MEMORY_READBACK_EN
        check("mod_readback", 64'(rd), 64'hBEEF);
`else
        check("mod_readback", 64'(rd), 64'h0);
`endif

        host_write(2'b10, 15'h00FF, 16'h0080);
        pwe_read(8'd255, rb);
        check("pwe_255", 64'(rb), 64'h80);
        i_mem_en = 1'b0; i_mem_we = 1'b1; i_mem_bram_select = 2'b10;
        i_mem_addr = 15'h00FF; i_mem_data_in = 16'h0011;
        @(negedge CLK);
        i_mem_we = 1'b0;
        pwe_read(8'd255, rb);
        check("pwe_en0_ignored", 64'(rb), 64'h80);
        host_write(2'b10, 15'h01FF, 16'h0033);
        pwe_read(8'd255, rb);
        check("pwe_unmapped", 64'(rb), 64'h80);
        host_write(2'b10, 15'h0000, 16'h12AB);
        pwe_read(8'd0, rb);
        check("pwe_low_byte", 64'(rb), 64'hAB);

        host_write(2'b00, 15'h0010, 16'h0000);
        for (int r = 0; r < 16; r++)
            for (int t = 0; t < 249; t++) begin
                exp0[r][t] = 16'($urandom());
                host_write(2'b11, 15'(r * 256 + t), exp0[r][t]);
            end
        for (int r = 0; r < 16; r++)
            for (int t = 0; t < 249; t++) begin
                stm_read(1'b0, 1'b0, 17'(r), 8'(t), rs);
                check("stm_gain_s0", rs, {48'd0, exp0[r][t]});
            end
        stm_read(1'b0, 1'b0, 17'd0, 8'd249, rs);
        check("stm_gain_oor", rs, 64'h0);

        host_write(2'b00, 15'h0010, 16'h0001);
        host_read(2'b00, 15'h0010, rd);
        check("stm_ctrl_seg1", 64'(rd), 64'h1);
        for (int r = 0; r < 4; r++)
            for (int t = 0; t < 249; t++) begin
                exp1[r][t] = 16'($urandom());
                host_write(2'b11, 15'(r * 256 + t), exp1[r][t]);
            end
        for (int r = 0; r < 4; r++)
            for (int t = 0; t < 249; t += 31) begin
                stm_read(1'b0, 1'b0, 17'(r), 8'(t), rs);
                check("stm_s0_kept", rs, {48'd0, exp0[r][t]});
                stm_read(1'b0, 1'b1, 17'(r), 8'(t), rs);
                check("stm_gain_s1", rs, {48'd0, exp1[r][t]});
            end
        stm_read(1'b1, 1'b1, 17'd0, 8'd0, rs);
        check("stm_focus_p0", rs, {exp1[0][3], exp1[0][2], exp1[0][1], exp1[0][0]});
        stm_read(1'b1, 1'b1, 17'd65, 8'd0, rs);
        check("stm_focus_p65", rs, {exp1[1][7], exp1[1][6], exp1[1][5], exp1[1][4]});
        host_read(2'b11, 15'h0003, rd);
`ifdef FPGA_MEMORY_READBACK_EN
        check("stm_readback", 64'(rd), 64'(exp1[0][3]));
`else
        check("stm_readback", 64'(rd), 64'h0);
`endif

        host_write(2'b00, 15'h0010, 16'h0002);
        host_write(2'b11, 15'h0000, 16'h7777);
        stm_read(1'b0, 1'b0, 17'd128, 8'd0, rs);
        check("stm_page1", rs, 64'h7777);
        stm_read(1'b0, 1'b0, 17'd0, 8'd0, rs);
        check("stm_page0_kept", rs, {48'd0, exp0[0][0]});

        host_read(2'b00, 15'h0005, rd);
        mod_read(1'b1, 15'd0, rb);
        i_mem_en = 1'b1; i_mem_we = 1'b1; i_mem_bram_select = 2'b00;
        i_mem_addr = 15'h0005; i_mem_data_in = 16'hFFFF;
        RST_N = 1'b0;
        #1;
        check("async_rst_data_out", 64'(o_mem_data_out), 64'h0);
        check("async_rst_mod", 64'(o_mod_value), 64'h0);
        check("async_rst_stm", o_stm_data, 64'h0);
        @(negedge CLK);
        i_mem_en = 1'b0; i_mem_we = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        host_read(2'b00, 15'h0005, rd);
        check("rst_write_dropped", 64'(rd), 64'h1234);
        host_read(2'b00, 15'h0010, rd);
        check("stm_ctrl_after_rst", 64'(rd), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
